// File: rtl/exception_controller.sv
// Exception/interrupt sequencer for the multicycle datapath: saves EPC and cause,
// fetches the handler vector, loads the PC, and services return-from-exception.
module exception_controller #(
   parameter logic [31:0] VEC_BASE = 32'h000000F0,
   parameter int unsigned MEM_LAT  = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fetch_boundary,
   input  logic        bad_op,
   input  logic        ovf_check,
   input  logic        ovf,
   input  logic        irq,
   input  logic        eret,
   input  logic [31:0] pc,
   input  logic [31:0] mem_rdata,
   output logic        exc_active,
   output logic        mem_addr_sel,
   output logic [31:0] mem_addr,
   output logic        pc_load,
   output logic [31:0] pc_value,
   output logic [31:0] epc,
   output logic [1:0]  cause,
   output logic        int_enable
);

   localparam int unsigned CNT_W = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SAVE   = 3'd1,
      VEC_RD = 3'd2,
      LOAD   = 3'd3,
      RET    = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] lat_cnt;
   logic             irq_meta;
   logic             irq_s;
   logic [1:0]       code_c;
   logic             take_c;
   logic             ret_c;

   // Two-flop synchroniser for the asynchronous interrupt level
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         irq_meta <= 1'b0;
         irq_s    <= 1'b0;
      end else begin
         irq_meta <= irq;
         irq_s    <= irq_meta;
      end
   end

   // Prioritised event encode; irq only counts at an instruction boundary
   always_comb begin
      code_c = 2'd0;
      if (bad_op)
         code_c = 2'd1;
      else if (ovf && ovf_check)
         code_c = 2'd2;
      else if (irq_s && int_enable && fetch_boundary)
         code_c = 2'd3;
   end

   assign take_c = (state == IDLE) && (code_c != 2'd0);
   assign ret_c  = (state == IDLE) && !take_c && eret;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         lat_cnt    <= '0;
         epc        <= '0;
         cause      <= 2'd0;
         int_enable <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               // Synchronous causes have already advanced PC past the faulting instruction
               if (take_c) begin
                  epc        <= (code_c == 2'd3) ? pc : pc - 32'd4;
                  cause      <= code_c;
                  int_enable <= 1'b0;
                  state      <= SAVE;
               end else if (ret_c) begin
                  state <= RET;
               end
            end
            SAVE: begin
               lat_cnt <= '0;
               state   <= VEC_RD;
            end
            VEC_RD: begin
               if (lat_cnt == CNT_W'(MEM_LAT - 1))
                  state <= LOAD;
               else
                  lat_cnt <= lat_cnt + CNT_W'(1);
            end
            LOAD: begin
               state <= IDLE;
            end
            RET: begin
               int_enable <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Datapath overrides decoded from the state register
   always_comb begin
      exc_active   = take_c || (state != IDLE);
      mem_addr_sel = 1'b0;
      mem_addr     = '0;
      pc_load      = 1'b0;
      pc_value     = '0;
      case (state)
         VEC_RD: begin
            mem_addr_sel = 1'b1;
            mem_addr     = VEC_BASE + 32'({cause, 2'b00});
         end
         LOAD: begin
            pc_load  = 1'b1;
            pc_value = {mem_rdata[31:2], 2'b00};
         end
         RET: begin
            pc_load  = 1'b1;
            pc_value = epc;
         end
         default: ;
      endcase
   end

endmodule
